jt12_timer_ab: RTL
==================

Name: jt12_timer_ab

Overview:
- Consumes the FM clock-enable stream and implements the OPN timer pair:
  - Timer A: 10-bit.
  - Timer B: 8-bit, with an extra /16 prescaler.
- Produces status flags, an active-low IRQ, and a Timer A overflow strobe for CSM key-on logic.
- Sits between the clock-enable divider and the register/status interface.
- All counting is gated by clk_en; it never free-runs on clk.

Parameters:
SAMPLE_DIV, 24, clk_en pulses per sample tick (Timer A count rate)
B_DIV, 16, sample ticks per Timer B count
A_W, 10, Timer A counter width
B_W, 8, Timer B counter width

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
clk_en  input  1  FM clock enable, one-clk pulse
value_A  input  A_W  Timer A reload value
value_B  input  B_W  Timer B reload value
load_A  input  1  Timer A run/load control (level)
load_B  input  1  Timer B run/load control (level)
flag_en_A  input  1  allow Timer A overflow to set flag_A
flag_en_B  input  1  allow Timer B overflow to set flag_B
clr_flag_A  input  1  clear flag_A (one-clk strobe)
clr_flag_B  input  1  clear flag_B (one-clk strobe)
flag_A  output  1  Timer A status flag
flag_B  output  1  Timer B status flag
ovf_A  output  1  one-clk pulse on every Timer A overflow, independent of flag_en_A
irq_n  output  1  ~(flag_A | flag_B), registered

Behaviour:
- Reset (rst_n low, async):
  - Counters and prescalers return to 0.
  - flag_A=0, flag_B=0, ovf_A=0, irq_n=1.
  - Load edge detectors return to 0.
- Sample prescaler (mod SAMPLE_DIV):
  - Advances on each clk_en. tick_s is asserted in the clk_en cycle in which the prescaler reads SAMPLE_DIV-1; the prescaler then wraps to 0.
  - Free-running; never reset by load_A or load_B.
- Timer B prescaler (mod B_DIV): advances on each tick_s; tick_b is asserted on the tick_s cycle where it reads B_DIV-1. Also free-running.
- Timer A per clk edge, in priority order:
  - load_A rising edge (registered previous value 0, current 1): cnt_A <= value_A immediately; no tick counted in that cycle.
  - load_A=0: cnt_A holds.
  - load_A=1 and tick_s:
    - cnt_A == 2^A_W-1: overflow. cnt_A <= value_A (value sampled at reload time), ovf_A pulses 1 clk, flag_A set if flag_en_A.
    - Otherwise cnt_A <= cnt_A+1.
- Timer B: identical to Timer A, using tick_b, value_B, load_B, flag_en_B and B_W. It has no overflow strobe output.
- Period in sample ticks is 2^W - value. value = max gives an overflow on every tick; value = 0 gives the full 2^W.
- A change of value_A or value_B mid-count takes effect only at the next reload or load edge.
- Flags:
  - Set and clear in the same cycle: set wins.
  - Clearing flag_en_x does not clear an already set flag.
  - Flags are sticky until clr_flag_x or reset.
- irq_n is registered: it follows flag changes one clk later.
- Deasserting load_x then reasserting it reloads the counter; the prescaler phase is unaffected.
- clk_en high on consecutive clks is legal; each high cycle counts as one pulse.

Test Plan:
- Reset: drive rst_n low mid-count with flag_A=1 -> all outputs return to reset values asynchronously, without waiting for a clk edge; after release, no ovf_A until load_A rises.
- Timer A period: clk_en every 6 clk, value_A=1020, load_A=1, flag_en_A=1 -> ovf_A pulses spaced exactly 4*24=96 clk_en (576 clk) apart; flag_A=1; irq_n=0 one clk after flag_A.
- Timer B period: value_B=254, load_B=1, flag_en_B=0 -> cnt_B overflows every 2*16*24=768 clk_en; flag_B stays 0 and irq_n stays 1.
- Flag race: assert clr_flag_A in the exact cycle of a Timer A overflow with flag_en_A=1 -> flag_A remains 1; clearing one cycle later -> flag_A=0 and irq_n returns to 1 the next clk.
- Load control: hold load_A=0 for 100 sample ticks -> cnt_A frozen, no ovf_A. Change value_A from 1020 to 1022 mid-count -> current period unchanged, next period is 2 ticks.
- Boundary: value_A=1023 -> ovf_A on every tick_s (every 24 clk_en). value_A=0 -> 1024 ticks between overflows.

Source files
------------

// File: rtl/jt12_timer_ab.sv
// OPN timer pair: 10-bit Timer A counting sample ticks and 8-bit Timer B
// counting sample ticks divided by a further /16. Both timers reload from
// their value registers on a load_x rising edge or on overflow. Overflows set
// sticky status flags, drive an active-low IRQ, and Timer A also emits a
// one-clk overflow strobe for CSM key-on.
//
// Signalling: there is no valid/ready handshake here. clk_en is a qualifier
// that is sampled on every clk edge, and each high cycle counts as one
// pulse. ovf_A is a one-clk strobe with no back-pressure. clr_flag_x are
// one-clk strobes that the block samples unconditionally.
module jt12_timer_ab #(
    parameter int SAMPLE_DIV = 24,
    parameter int B_DIV      = 16,
    parameter int A_W        = 10,
    parameter int B_W        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    input  logic [A_W-1:0] value_A,
    input  logic [B_W-1:0] value_B,
    input  logic           load_A,
    input  logic           load_B,
    input  logic           flag_en_A,
    input  logic           flag_en_B,
    input  logic           clr_flag_A,
    input  logic           clr_flag_B,
    output logic           flag_A,
    output logic           flag_B,
    output logic           ovf_A,
    output logic           irq_n
);

    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PW = (B_DIV > 1) ? $clog2(B_DIV) : 1;

    logic [SW-1:0]  div_s;
    logic [PW-1:0]  div_b;
    logic [A_W-1:0] cnt_A;
    logic [B_W-1:0] cnt_B;
    logic           load_A_l;
    logic           load_B_l;

    logic tick_s;
    logic tick_b;
    logic ld_edge_A;
    logic ld_edge_B;
    logic ovf_now_A;
    logic ovf_now_B;

    // Tick and overflow qualifiers. A load edge takes priority over a tick,
    // so a tick that coincides with a load edge is not counted.
    always_comb begin
        tick_s    = clk_en && (div_s == SW'(SAMPLE_DIV - 1));
        tick_b    = tick_s && (div_b == PW'(B_DIV - 1));
        ld_edge_A = load_A && !load_A_l;
        ld_edge_B = load_B && !load_B_l;
        ovf_now_A = !ld_edge_A && load_A && tick_s && (cnt_A == {A_W{1'b1}});
        ovf_now_B = !ld_edge_B && load_B && tick_b && (cnt_B == {B_W{1'b1}});
    end

    // Free-running prescalers. They are never touched by the load controls,
    // so the tick phase survives reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_s <= '0;
            div_b <= '0;
        end else if (clk_en) begin
            div_s <= tick_s ? '0 : div_s + SW'(1);
            if (tick_s)
                div_b <= tick_b ? '0 : div_b + PW'(1);
        end
    end

    // Registered previous load levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_A_l <= 1'b0;
            load_B_l <= 1'b0;
        end else begin
            load_A_l <= load_A;
            load_B_l <= load_B;
        end
    end

    // Timer A counter: reload on load edge or overflow, count up on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_A <= '0;
        end else if (ld_edge_A || ovf_now_A) begin
            cnt_A <= value_A;
        end else if (load_A && tick_s) begin
            cnt_A <= cnt_A + A_W'(1);
        end
    end

    // Timer B counter: same rules as Timer A, but clocked by tick_b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_B <= '0;
        end else if (ld_edge_B || ovf_now_B) begin
            cnt_B <= value_B;
        end else if (load_B && tick_b) begin
            cnt_B <= cnt_B + B_W'(1);
        end
    end

    // Sticky flags: set wins over clear. ovf_A strobes on every A overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_A <= 1'b0;
            flag_B <= 1'b0;
            ovf_A  <= 1'b0;
        end else begin
            ovf_A <= ovf_now_A;
            if (ovf_now_A && flag_en_A)
                flag_A <= 1'b1;
            else if (clr_flag_A)
                flag_A <= 1'b0;
            if (ovf_now_B && flag_en_B)
                flag_B <= 1'b1;
            else if (clr_flag_B)
                flag_B <= 1'b0;
        end
    end

    // IRQ follows the registered flags one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_n <= 1'b1;
        else
            irq_n <= !(flag_A || flag_B);
    end

endmodule
